// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read RAM port between two req/ack requesters.
// Four clocks per access (grant, issue, wait, done); a waiting requester is stalled by withholding its ack.
module dpram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic                    last_grant_q, last_grant_d;
    logic                    rd_q, rd_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic [ADDR_WIDTH-1:0]   ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0]   ram_data_q, ram_data_d;
    logic                    ram_wren_q, ram_wren_d;
    logic                    pick;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_grant_d  = last_grant_q;
        rd_d          = rd_q;
        ack0_d        = ack0_q;
        ack1_d        = ack1_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = ram_wren_q;
        // requester 1 wins when it is alone, or on a tie when requester 0 was served last
        pick          = req1 & (~req0 | ~last_grant_q);

        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    gnt_d         = pick;
                    last_grant_d  = pick;
                    ram_address_d = pick ? addr1  : addr0;
                    ram_data_d    = pick ? wdata1 : wdata0;
                    ram_wren_d    = pick ? we1    : we0;
                    rd_d          = pick ? ~we1   : ~we0;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_wren_d = 1'b0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (gnt_q) begin
                    ack1_d = 1'b1;
                    if (rd_q) rdata1_d = ram_q;
                end else begin
                    ack0_d = 1'b1;
                    if (rd_q) rdata0_d = ram_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            rd_q          <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_grant_q  <= last_grant_d;
            rd_q          <= rd_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;

endmodule
